// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device emulator answering an SDRAM controller's command bus.
// Latency: writes land on the command edge; read data is driven for one cycle, CL clocks after the READ edge.
// Backpressure: none; every command is consumed on the edge it is sampled, and illegal ones only raise a sticky error.
module sdram_responder #(
   parameter int MEM_AW = 12,
   parameter int TRCD   = 2
) (
   input  logic        clk,
   input  logic        init,
   input  logic [15:0] sd_data_in,
   output logic [15:0] sd_data_out,
   output logic        sd_data_oe,
   input  logic [12:0] sd_addr,
   input  logic [1:0]  sd_ba,
   input  logic [1:0]  sd_dqm,
   input  logic        sd_cs,
   input  logic        sd_ras,
   input  logic        sd_cas,
   input  logic        sd_we,
   output logic        mode_valid,
   output logic [15:0] refresh_count,
   output logic        proto_err,
   output logic [2:0]  err_code
);

   // {cs,ras,cas,we}; anything with cs high is an inhibit
   localparam logic [3:0] CMD_LMR = 4'b0000;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_RD  = 4'b0101;

   // ACTIVE loads TRCD-1 so that a READ/WRITE exactly TRCD clocks later sees zero
   localparam logic [7:0] TRCD_LD = 8'(TRCD - 1);

   typedef enum logic {
      BANK_IDLE   = 1'b0,
      BANK_ACTIVE = 1'b1
   } bank_state_t;

   bank_state_t       bank_st  [4];
   bank_state_t       st_nxt   [4];
   logic [12:0]       bank_row [4];
   logic [12:0]       row_nxt  [4];
   logic [7:0]        bank_cnt [4];
   logic [7:0]        cnt_nxt  [4];

   logic [15:0]       mem [2**MEM_AW];
   logic [MEM_AW-1:0] mem_idx;
   logic [3:0]        cmd;
   logic              any_active;
   logic              mode_ok;
   logic              cl3_q;
   logic              err_hit;
   logic [2:0]        err_val;
   logic              wr_en;
   logic              rd_en;
   logic              lmr_en;
   logic              ref_en;
   logic [15:0]       rd_mask;

   // Read delay line: slot 3 is the CL3 entry point, slot 2 the CL2 entry point,
   // slot 1 feeds the output register.
   logic [3:1]        pipe_vld;
   logic [15:0]       pipe_dat [1:3];

   assign cmd     = {sd_cs, sd_ras, sd_cas, sd_we};
   assign mem_idx = MEM_AW'({sd_ba, bank_row[sd_ba], sd_addr[8:0]});
   assign rd_mask = {{8{~sd_dqm[1]}}, {8{~sd_dqm[0]}}};
   assign mode_ok = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) &&
                    (sd_addr[2:0] == 3'd0) && sd_addr[9];

   // True when any bank holds an open row (blocks refresh and mode load).
   always_comb begin
      any_active = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (bank_st[b] == BANK_ACTIVE) any_active = 1'b1;
      end
   end

   // Command decode, per-bank next state and protocol checks.
   always_comb begin
      st_nxt  = bank_st;
      row_nxt = bank_row;
      for (int b = 0; b < 4; b++) begin
         cnt_nxt[b] = (bank_cnt[b] != 8'd0) ? bank_cnt[b] - 8'd1 : 8'd0;
      end
      err_hit = 1'b0;
      err_val = 3'd0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      lmr_en  = 1'b0;
      ref_en  = 1'b0;
      if (!init) begin
         case (cmd)
            CMD_ACT: begin
               if (bank_st[sd_ba] == BANK_ACTIVE) begin
                  err_hit = 1'b1;
                  err_val = 3'd1;
               end else begin
                  st_nxt[sd_ba]  = BANK_ACTIVE;
                  row_nxt[sd_ba] = sd_addr;
                  cnt_nxt[sd_ba] = TRCD_LD;
               end
            end
            CMD_RD, CMD_WR: begin
               if (bank_st[sd_ba] == BANK_IDLE) begin
                  err_hit = 1'b1;
                  err_val = 3'd2;
               end else if (bank_cnt[sd_ba] != 8'd0) begin
                  err_hit = 1'b1;
                  err_val = 3'd3;
               end else if (!mode_valid) begin
                  err_hit = 1'b1;
                  err_val = 3'd4;
               end else begin
                  if (cmd == CMD_WR) begin
                     wr_en = 1'b1;
                     // controller drove write data while we were driving a read beat
                     if (sd_data_oe) begin
                        err_hit = 1'b1;
                        err_val = 3'd5;
                     end
                  end else begin
                     rd_en = 1'b1;
                  end
                  // auto-precharge closes the row at the command edge
                  if (sd_addr[10]) st_nxt[sd_ba] = BANK_IDLE;
               end
            end
            CMD_PRE: begin
               if (sd_addr[10]) begin
                  for (int b = 0; b < 4; b++) st_nxt[b] = BANK_IDLE;
               end else begin
                  st_nxt[sd_ba] = BANK_IDLE;
               end
            end
            CMD_REF: begin
               if (any_active) begin
                  err_hit = 1'b1;
                  err_val = 3'd6;
               end else begin
                  ref_en = 1'b1;
               end
            end
            CMD_LMR: begin
               if (any_active) begin
                  err_hit = 1'b1;
                  err_val = 3'd6;
               end else begin
                  lmr_en = 1'b1;
                  if (!mode_ok) begin
                     err_hit = 1'b1;
                     err_val = 3'd7;
                  end
               end
            end
            default: begin
               // inhibit, NOP and burst terminate leave everything unchanged
            end
         endcase
      end
   end

   // Per-bank state register: open/closed, open row and tRCD down-counter.
   always_ff @(posedge clk) begin
      if (init) begin
         for (int b = 0; b < 4; b++) begin
            bank_st[b]  <= BANK_IDLE;
            bank_row[b] <= 13'd0;
            bank_cnt[b] <= 8'd0;
         end
      end else begin
         bank_st  <= st_nxt;
         bank_row <= row_nxt;
         bank_cnt <= cnt_nxt;
      end
   end

   // Byte-lane writes into the emulated array; contents survive init.
   always_ff @(posedge clk) begin
      if (wr_en && !sd_dqm[0]) mem[mem_idx][7:0]  <= sd_data_in[7:0];
      if (wr_en && !sd_dqm[1]) mem[mem_idx][15:8] <= sd_data_in[15:8];
   end

   // Read pipeline: array read at the command edge, entered at the slot matching
   // the CL in force at that moment, so a later mode load cannot retime it.
   always_ff @(posedge clk) begin
      if (init) begin
         pipe_vld    <= 3'b000;
         for (int s = 1; s <= 3; s++) pipe_dat[s] <= 16'd0;
         sd_data_oe  <= 1'b0;
         sd_data_out <= 16'd0;
      end else begin
         sd_data_oe  <= pipe_vld[1];
         sd_data_out <= pipe_vld[1] ? pipe_dat[1] : 16'd0;
         pipe_vld[1] <= pipe_vld[2];
         pipe_dat[1] <= pipe_dat[2];
         pipe_vld[2] <= pipe_vld[3];
         pipe_dat[2] <= pipe_dat[3];
         pipe_vld[3] <= 1'b0;
         pipe_dat[3] <= 16'd0;
         if (rd_en) begin
            if (cl3_q) begin
               pipe_vld[3] <= 1'b1;
               pipe_dat[3] <= mem[mem_idx] & rd_mask;
            end else begin
               pipe_vld[2] <= 1'b1;
               pipe_dat[2] <= mem[mem_idx] & rd_mask;
            end
         end
      end
   end

   // Mode register, refresh counter and first-error latch.
   always_ff @(posedge clk) begin
      if (init) begin
         mode_valid    <= 1'b0;
         cl3_q         <= 1'b0;
         refresh_count <= 16'd0;
         proto_err     <= 1'b0;
         err_code      <= 3'd0;
      end else begin
         if (lmr_en) begin
            mode_valid <= mode_ok;
            if (mode_ok) cl3_q <= (sd_addr[6:4] == 3'd3);
         end
         if (ref_en) refresh_count <= refresh_count + 16'd1;
         if (err_hit && !proto_err) begin
            proto_err <= 1'b1;
            err_code  <= err_val;
         end
      end
   end

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed bench for the SDRAM device emulator.
// Drives commands 1 time unit after the rising edge and samples 1 unit after the following edge.
// The emulator has no backpressure, so every step is a fixed number of clocks.
module tb_sdram_responder;

   localparam logic [3:0] C_LMR = 4'b0000;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_NOP = 4'b0111;

   logic        clk = 1'b0;
   logic        init;
   logic [15:0] sd_data_in;
   logic [15:0] sd_data_out;
   logic        sd_data_oe;
   logic [12:0] sd_addr;
   logic [1:0]  sd_ba;
   logic [1:0]  sd_dqm;
   logic        sd_cs;
   logic        sd_ras;
   logic        sd_cas;
   logic        sd_we;
   logic        mode_valid;
   logic [15:0] refresh_count;
   logic        proto_err;
   logic [2:0]  err_code;

   int total = 0;
   int bad   = 0;

   sdram_responder #(.MEM_AW(12), .TRCD(2)) dut (
      .clk           (clk),
      .init          (init),
      .sd_data_in    (sd_data_in),
      .sd_data_out   (sd_data_out),
      .sd_data_oe    (sd_data_oe),
      .sd_addr       (sd_addr),
      .sd_ba         (sd_ba),
      .sd_dqm        (sd_dqm),
      .sd_cs         (sd_cs),
      .sd_ras        (sd_ras),
      .sd_cas        (sd_cas),
      .sd_we         (sd_we),
      .mode_valid    (mode_valid),
      .refresh_count (refresh_count),
      .proto_err     (proto_err),
      .err_code      (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // present one command for one rising edge, then return to NOP
   task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                        input logic [1:0] dqm, input logic [15:0] dat);
      {sd_cs, sd_ras, sd_cas, sd_we} = c;
      sd_ba      = ba;
      sd_addr    = addr;
      sd_dqm     = dqm;
      sd_data_in = dat;
      @(posedge clk);
      #1;
      {sd_cs, sd_ras, sd_cas, sd_we} = C_NOP;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_init(input int n);
      init = 1'b1;
      tick(n);
      init = 1'b0;
   endtask

   initial begin
      init       = 1'b1;
      {sd_cs, sd_ras, sd_cas, sd_we} = C_NOP;
      sd_ba      = 2'd0;
      sd_addr    = 13'd0;
      sd_dqm     = 2'b00;
      sd_data_in = 16'd0;
      do_init(2);

      // reset state
      chk("rst_oe",      16'(sd_data_oe),    16'd0);
      chk("rst_dout",    sd_data_out,        16'd0);
      chk("rst_modev",   16'(mode_valid),    16'd0);
      chk("rst_refcnt",  refresh_count,      16'd0);
      chk("rst_perr",    16'(proto_err),     16'd0);
      chk("rst_ecode",   16'(err_code),      16'd0);

      // CL3 write then read
      issue(C_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
      chk("cl3_modev", 16'(mode_valid), 16'd1);
      issue(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
      tick(1);
      issue(C_WR,  2'd1, 13'h412, 2'b00, 16'hBEEF);
      issue(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
      tick(1);
      issue(C_RD,  2'd1, 13'h012, 2'b00, 16'h0);
      chk("cl3_oe_n",   16'(sd_data_oe), 16'd0);
      tick(1);
      chk("cl3_oe_n1",  16'(sd_data_oe), 16'd0);
      tick(1);
      chk("cl3_oe_n2",  16'(sd_data_oe), 16'd0);
      tick(1);
      chk("cl3_oe_n3",  16'(sd_data_oe), 16'd1);
      chk("cl3_data",   sd_data_out,     16'hBEEF);
      tick(1);
      chk("cl3_oe_n4",  16'(sd_data_oe), 16'd0);
      chk("cl3_perr",   16'(proto_err),  16'd0);

      // CL2 read, then three back-to-back reads
      issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 13'h220, 2'b00, 16'h0);
      chk("cl2_modev", 16'(mode_valid), 16'd1);
      issue(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
      tick(1);
      issue(C_RD,  2'd1, 13'h012, 2'b00, 16'h0);
      tick(1);
      chk("cl2_oe_n1",  16'(sd_data_oe), 16'd0);
      tick(1);
      chk("cl2_oe_n2",  16'(sd_data_oe), 16'd1);
      chk("cl2_data",   sd_data_out,     16'hBEEF);
      tick(1);
      chk("cl2_oe_n3",  16'(sd_data_oe), 16'd0);
      issue(C_WR, 2'd1, 13'h020, 2'b00, 16'h1111);
      issue(C_WR, 2'd1, 13'h021, 2'b00, 16'h2222);
      issue(C_WR, 2'd1, 13'h022, 2'b00, 16'h3333);
      issue(C_RD, 2'd1, 13'h020, 2'b00, 16'h0);
      issue(C_RD, 2'd1, 13'h021, 2'b00, 16'h0);
      chk("b2b_oe_pre", 16'(sd_data_oe), 16'd0);
      issue(C_RD, 2'd1, 13'h022, 2'b00, 16'h0);
      chk("b2b_oe_0",   16'(sd_data_oe), 16'd1);
      chk("b2b_dat_0",  sd_data_out,     16'h1111);
      tick(1);
      chk("b2b_oe_1",   16'(sd_data_oe), 16'd1);
      chk("b2b_dat_1",  sd_data_out,     16'h2222);
      tick(1);
      chk("b2b_oe_2",   16'(sd_data_oe), 16'd1);
      chk("b2b_dat_2",  sd_data_out,     16'h3333);
      tick(1);
      chk("b2b_oe_end", 16'(sd_data_oe), 16'd0);

      // byte masks on write and read
      issue(C_WR, 2'd1, 13'h030, 2'b00, 16'h1234);
      issue(C_WR, 2'd1, 13'h030, 2'b10, 16'hABCD);
      issue(C_RD, 2'd1, 13'h030, 2'b00, 16'h0);
      tick(2);
      chk("wmask_oe",   16'(sd_data_oe), 16'd1);
      chk("wmask_data", sd_data_out,     16'h12CD);
      issue(C_RD, 2'd1, 13'h030, 2'b01, 16'h0);
      tick(2);
      chk("rmask_oe",   16'(sd_data_oe), 16'd1);
      chk("rmask_data", sd_data_out,     16'h1200);
      chk("mask_perr",  16'(proto_err),  16'd0);

      // refresh counting and refresh with an open bank
      issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
      for (int i = 0; i < 10; i++) issue(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
      chk("ref_cnt10",  refresh_count,   16'd10);
      chk("ref_perr0",  16'(proto_err),  16'd0);
      issue(C_ACT, 2'd3, 13'h001, 2'b00, 16'h0);
      issue(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
      chk("ref_cnt_blk", refresh_count,  16'd10);
      chk("ref_perr1",  16'(proto_err),  16'd1);
      chk("ref_ecode",  16'(err_code),   16'd6);

      // init clears status; double ACTIVE latches code 1, later errors do not overwrite
      do_init(2);
      chk("i2_perr",    16'(proto_err),     16'd0);
      chk("i2_ecode",   16'(err_code),      16'd0);
      chk("i2_refcnt",  refresh_count,      16'd0);
      chk("i2_modev",   16'(mode_valid),    16'd0);
      issue(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0);
      issue(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0);
      chk("dact_perr",  16'(proto_err),  16'd1);
      chk("dact_ecode", 16'(err_code),   16'd1);
      issue(C_ACT, 2'd2, 13'h000, 2'b00, 16'h0);
      issue(C_RD,  2'd2, 13'h000, 2'b00, 16'h0);
      chk("trcd_ecode", 16'(err_code),   16'd1);

      // init during an in-flight read flushes the beat and keeps memory
      do_init(2);
      issue(C_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
      issue(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
      tick(1);
      issue(C_RD,  2'd1, 13'h012, 2'b00, 16'h0);
      chk("flush_oe_n", 16'(sd_data_oe), 16'd0);
      init = 1'b1;
      tick(1);
      chk("flush_oe_1", 16'(sd_data_oe), 16'd0);
      tick(1);
      chk("flush_oe_2", 16'(sd_data_oe), 16'd0);
      tick(1);
      chk("flush_oe_3", 16'(sd_data_oe), 16'd0);
      init = 1'b0;
      tick(1);
      chk("flush_oe_4", 16'(sd_data_oe), 16'd0);
      tick(1);
      chk("flush_oe_5", 16'(sd_data_oe), 16'd0);
      chk("flush_dout", sd_data_out,     16'd0);
      chk("flush_modev", 16'(mode_valid), 16'd0);
      chk("flush_ref",  refresh_count,   16'd0);
      chk("flush_perr", 16'(proto_err),  16'd0);
      chk("flush_ecode", 16'(err_code),  16'd0);
      issue(C_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
      issue(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
      tick(1);
      issue(C_RD,  2'd1, 13'h012, 2'b00, 16'h0);
      tick(3);
      chk("keep_oe",    16'(sd_data_oe), 16'd1);
      chk("keep_data",  sd_data_out,     16'hBEEF);
      chk("keep_perr",  16'(proto_err),  16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
Synthesizable SDR SDRAM device emulator: the chip-side responder to the team's SDRAM controller. It decodes the MT48LC16M16-style command bus, tracks per-bank row state, honours mode-register CAS latency and serves reads/writes from an internal block-RAM array. It is used on boards without SDRAM and as a bus-level checker in simulation. The data bus is split into in/out/oe because there are no internal tristates.

Parameters:
MEM_AW, 12, log2 of internal word count; the memory index is the low MEM_AW bits of {ba, row, col}
TRCD, 2, minimum clocks from ACTIVE to READ/WRITE on the same bank

Ports:
clk  in  1  memory clock, all logic on rising edge
init  in  1  synchronous active-high reset
sd_data_in  in  16  write data from controller
sd_data_out  out  16  read data to controller
sd_data_oe  out  1  high while sd_data_out carries valid read data
sd_addr  in  13  multiplexed row/column address
sd_ba  in  2  bank select
sd_dqm  in  2  byte masks, [1]=upper, active high
sd_cs  in  1  chip select, active low
sd_ras  in  1  row address strobe, active low
sd_cas  in  1  column address strobe, active low
sd_we  in  1  write enable, active low
mode_valid  out  1  mode register loaded with a supported value
refresh_count  out  16  AUTO_REFRESH commands accepted, wraps at 0xFFFF->0
proto_err  out  1  sticky protocol-violation flag
err_code  out  3  code of the first violation since init

Behaviour:
- Command is {cs,ras,cas,we}, sampled every edge. INHIBIT (cs=1) and NOP (0111) do nothing. BURST_TERMINATE (0110) is ignored.
- init=1: all banks IDLE, mode_valid=0, refresh_count=0, proto_err=0, err_code=0, read pipeline flushed, sd_data_oe=0, sd_data_out=0. Commands in the same cycle are ignored. Memory contents are kept.
- Per-bank state is IDLE/ACTIVE, with a 13-bit open row and a tRCD down-counter.
- ACTIVE (0011): an IDLE bank goes ACTIVE and stores row=sd_addr, counter=TRCD-1. An already-ACTIVE bank sets err 1 and state is unchanged.
- READ (0101) / WRITE (0100): col=sd_addr[8:0], A10=auto-precharge.
  - Bank IDLE: err 2, ignored.
  - Counter nonzero: err 3, ignored.
  - mode_valid=0: err 4, ignored.
- WRITE: memory[{ba,row,col}] is updated on the same edge. Byte lane i is written only when sd_dqm[i]=0. With A10=1 the bank is IDLE on the next cycle.
- READ: synchronous RAM read at the command edge, then delayed. Command sampled at edge n means sd_data_oe=1 and data valid for exactly the cycle after edge n+CL, and 0 otherwise.
  - DQM is latched at the command; masked lanes output 0x00.
  - With A10=1 the bank returns IDLE at the command edge; a new ACTIVE is legal on the next cycle.
  - Back-to-back READs each produce one data beat, pipelined, for 1/clk throughput.
- WRITE issued while a read beat is scheduled to be driven in that cycle: err 5, and the write still occurs.
- PRECHARGE (0010): A10=1 sets all banks IDLE; otherwise bank sd_ba goes IDLE. Precharging an IDLE bank is legal.
- AUTO_REFRESH (0001): all banks must be IDLE, otherwise err 6 and no count. refresh_count increments only on legal refresh.
- LOAD_MODE (0000): all banks must be IDLE, otherwise err 6. The mode is stored from sd_addr[9:0].
  - Accepted only if CL (A6:4) is 2 or 3, burst length (A2:0)=000 and A9=1; then mode_valid=1.
  - Otherwise err 7, and mode_valid=0 until a good load.
- A later LOAD_MODE changes CL only for READs issued after it; in-flight beats keep their original latency.
- Errors: proto_err sets on the first error. err_code latches the first code and is not overwritten; only init clears both.
- Counters decrement to 0 and saturate there.

Test Plan:
- init, LOAD_MODE addr=0x230 (CL3), ACTIVE ba=1 row=0x005, wait 2, WRITE col=0x012 data=0xBEEF dqm=00 A10=1, ACTIVE again, READ col=0x012 at edge n -> oe=1 only after edge n+3, data=0xBEEF, proto_err=0.
- Same flow with mode 0x220 (CL2) -> data after edge n+2; three back-to-back READs give three consecutive beats.
- Write 0x1234 then WRITE 0xABCD with dqm=10 -> readback 0x12CD; READ with dqm=01 -> 0x1200.
- ACTIVE bank 0 twice -> proto_err=1, err_code=1. A subsequent READ 1 cycle after ACTIVE on bank 2 leaves err_code at 1.
- Ten AUTO_REFRESH with all banks idle -> refresh_count=10. One with bank 3 open -> count stays 10, err 6.
- READ issued, then init asserted before the data beat -> no oe pulse, all status outputs are 0, and memory still holds the prior data.
